// File: rtl/bcd_counter_n.sv
// Cascadable up/down BCD counter of NUM_DIGITS decimal digits with parallel load and wrap or saturate.
// Define BCD_LOAD_CHECK_EN to reject loads containing non-BCD nibbles and report them on load_err.
module bcd_counter_n #(
   parameter int NUM_DIGITS = 4,
   parameter int SATURATE   = 0
) (
   input  logic                    sys_clk,
   input  logic                    sys_reset_n,
   input  logic                    tick_in,
   input  logic                    up_down,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   output logic [4*NUM_DIGITS-1:0] count,
   output logic                    tick_out,
   output logic                    at_max,
   output logic                    at_zero,
   output logic                    load_err
);

   localparam int W   = 4 * NUM_DIGITS;
   localparam bit SAT = (SATURATE != 0);

   logic [W-1:0] count_q;
   logic [W-1:0] next_up;
   logic [W-1:0] next_down;
   logic         load_accept;

   // Non-BCD digits recover on any tick: up forces 0 and passes a carry, down forces 9 with no borrow.
   always_comb begin
      logic [3:0] d;
      logic       up_c;
      logic       dn_c;
      next_up   = '0;
      next_down = '0;
      at_max    = 1'b1;
      at_zero   = 1'b1;
      up_c      = 1'b1;
      dn_c      = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         d       = count_q[4*k +: 4];
         at_max  = at_max  & (d == 4'd9);
         at_zero = at_zero & (d == 4'd0);

         if (d > 4'd9) begin
            next_up[4*k +: 4] = 4'd0;
            up_c              = 1'b1;
         end else if (up_c) begin
            if (d == 4'd9) begin
               next_up[4*k +: 4] = 4'd0;
               up_c              = 1'b1;
            end else begin
               next_up[4*k +: 4] = d + 4'd1;
               up_c              = 1'b0;
            end
         end else begin
            next_up[4*k +: 4] = d;
         end

         if (d > 4'd9) begin
            next_down[4*k +: 4] = 4'd9;
            dn_c                = 1'b0;
         end else if (dn_c) begin
            if (d == 4'd0) begin
               next_down[4*k +: 4] = 4'd9;
               dn_c                = 1'b1;
            end else begin
               next_down[4*k +: 4] = d - 4'd1;
               dn_c                = 1'b0;
            end
         end else begin
            next_down[4*k +: 4] = d;
         end
      end
   end

   // Carry/borrow out ignores SATURATE so a higher-order stage sees the boundary crossing either way.
   assign tick_out = tick_in & ~load & ((up_down & at_max) | (~up_down & at_zero));
   assign count    = count_q;

`ifdef BCD_LOAD_CHECK_EN
   logic load_bad;
   logic load_err_q;

   always_comb begin
      load_bad = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         load_bad = load_bad | (load_value[4*k +: 4] > 4'd9);
      end
   end

   assign load_accept = ~load_bad;

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         load_err_q <= 1'b0;
      end else begin
         load_err_q <= load & load_bad;
      end
   end

   assign load_err = load_err_q;
`else
   assign load_accept = 1'b1;
   assign load_err    = 1'b0;
`endif

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         count_q <= '0;
      end else if (load) begin
         if (load_accept) begin
            count_q <= load_value;
         end
      end else if (tick_in) begin
         if (up_down) begin
            if (!(SAT && at_max)) begin
               count_q <= next_up;
            end
         end else begin
            if (!(SAT && at_zero)) begin
               count_q <= next_down;
            end
         end
      end
   end

endmodule

// File: doc/bcd_counter_n.md
BCD_COUNTER_N -- requirements
Module: bcd_counter_n

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning the number of cascaded decimal digits (legal range 1-8).
REQ-002 SHALL have parameter SATURATE, default 0, meaning 0 = wrap at the boundary and 1 = hold at the boundary.
REQ-003 SHALL have port sys_clk  input  1  continuous system clock; all state changes on its rising edge.
REQ-004 SHALL have port sys_reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port tick_in  input  1  count one step when high.
REQ-006 SHALL have port up_down  input  1  direction: 1 = up, 0 = down.
REQ-007 SHALL have port load  input  1  parallel load request.
REQ-008 SHALL have port load_value  input  4*NUM_DIGITS  BCD value to load; digit 0 is bits [3:0].
REQ-009 SHALL have port count  output  4*NUM_DIGITS  registered BCD count; digit 0 is least significant.
REQ-010 SHALL have port tick_out  output  1  cascade carry/borrow to a higher-order counter.
REQ-011 SHALL have port at_max  output  1  all digits equal 9.
REQ-012 SHALL have port at_zero  output  1  all digits equal 0.
REQ-013 SHALL have port load_err  output  1  rejected-load pulse (see Configuration).

Function
REQ-014 Priority SHALL be: reset, then load, then tick_in, then hold.
REQ-015 When load is accepted, count SHALL equal load_value after the next edge, and tick_in SHALL be ignored in that cycle.
REQ-016 On an up tick, digit k SHALL increment when k = 0 or all lower digits are 9; a digit at 9 or above SHALL become 0.
REQ-017 On a down tick, digit k SHALL decrement when k = 0 or all lower digits are 0; a digit at 0 SHALL become 9, and a digit above 9 SHALL become 9.
REQ-018 With SATURATE=0, up from all-9s SHALL give all-0s, and down from all-0s SHALL give all-9s.
REQ-019 With SATURATE=1, an up tick at all-9s and a down tick at all-0s SHALL leave count unchanged.
REQ-020 tick_out SHALL be combinational: tick_in & ~load & ((up_down & at_max) | (~up_down & at_zero)), independent of SATURATE.
REQ-021 at_max and at_zero SHALL be combinational decodes of count with zero latency.
REQ-022 Count SHALL update exactly one edge after tick_in is sampled high; there SHALL be no internal prescaling.
REQ-023 A change of up_down SHALL take effect in the same cycle it is sampled, with no pipeline delay.

Reset
REQ-024 While sys_reset_n is 0, count SHALL be all-zero, load_err SHALL be 0, and at_zero SHALL be 1, without waiting for a clock edge.
REQ-025 Reset assertion mid-count or mid-load SHALL abort the operation; the first edge after deassertion SHALL process inputs normally.

Configuration
REQ-026 When macro BCD_LOAD_CHECK_EN is defined, a load with any load_value nibble above 9 SHALL be rejected: count unchanged, tick_in ignored that cycle, load_err high for exactly one cycle after the edge.
REQ-027 When BCD_LOAD_CHECK_EN is defined, a valid load SHALL clear load_err on the next edge.
REQ-028 When BCD_LOAD_CHECK_EN is undefined, load_value SHALL be loaded verbatim and load_err SHALL be constant 0; invalid digits are then recovered per REQ-016/017.

Verification (NUM_DIGITS=4)
REQ-029 SATURATE=0, count=0999, up tick -> count=1000, tick_out=0.
REQ-030 SATURATE=0, count=9999, up tick -> tick_out=1 during the tick cycle, count=0000 next cycle.
REQ-031 SATURATE=0, count=0000, down tick -> tick_out=1, count=9999. SATURATE=1, same stimulus -> count stays 0000, tick_out=1.
REQ-032 load=1, load_value=4271, tick_in=1, up_down=1 -> count=4271, tick_out=0.
REQ-033 With BCD_LOAD_CHECK_EN, load_value=12A4 -> count unchanged, load_err=1 for one cycle. Without it -> count=12A4, next up tick gives 1305.
REQ-034 sys_reset_n pulsed low asynchronously between edges while count=5678 -> count=0000 and at_zero=1 immediately, before the next edge.
